// File: rtl/adc_scan_ctrl.sv
// Scan controller for an 8-channel multiplexed ADC: walks the enabled channels,
// sequences the ADC strobes and keeps the latest conversion of each channel in a table.
module adc_scan_ctrl #(
  parameter int CLK_DIV = 25,
  parameter int TIMEOUT = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] ch_mask,
  input  logic       eoc,
  input  logic [7:0] result,
  output logic       start,
  output logic       ale,
  output logic       out_en,
  output logic       adc_clk,
  output logic [2:0] addr,
  output logic       sample_valid,
  output logic [2:0] sample_ch,
  output logic [7:0] sample_data,
  input  logic [2:0] rd_ch,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       timeout_err,
  output logic [2:0] dbg_state
);
  typedef enum logic [2:0] {
    IDLE, SEL, LATCH, CONV, WAIT_LO, WAIT_HI, READ, STORE
  } state_t;

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  state_t           state, state_nx;
  logic [1:0]       phase;
  logic [TO_W-1:0]  to_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       data_reg;
  logic [7:0]       table_q [8];
  logic             to_last, to_fire, scan_more;
  logic             start_nx, ale_nx, out_en_nx, busy_nx;

  // Channel walk: a fresh scan starts at the lowest enabled channel; later steps
  // take the first enabled channel above the current one, wrapping 7 -> 0.
  function automatic logic [2:0] lowest_ch(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) if (m[i]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [7:0] m);
    logic [2:0] r;
    logic [2:0] idx;
    r = cur;
    for (int i = 7; i >= 1; i--) begin
      idx = cur + 3'(i);
      if (m[idx]) r = idx;
    end
    return r;
  endfunction

  assign scan_more = enable && (ch_mask != 8'h00);
  assign to_last   = (to_cnt == TO_W'(TIMEOUT - 1));
  assign rd_data   = table_q[rd_ch];
  assign dbg_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      adc_clk <= 1'b0;
    end else if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
      div_cnt <= '0;
      adc_clk <= ~adc_clk;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      phase        <= '0;
      to_cnt       <= '0;
      addr         <= '0;
      data_reg     <= '0;
      start        <= 1'b0;
      ale          <= 1'b0;
      out_en       <= 1'b0;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      timeout_err  <= 1'b0;
      for (int i = 0; i < 8; i++) table_q[i] <= '0;
    end else begin
      state  <= state_nx;
      phase  <= (state_nx != state) ? 2'd0 : phase + 2'd1;
      to_cnt <= (state == WAIT_LO || state == WAIT_HI) ? to_cnt + TO_W'(1) : '0;
      start  <= start_nx;
      ale    <= ale_nx;
      out_en <= out_en_nx;
      busy   <= busy_nx;
      if (state == IDLE && state_nx == SEL)
        addr <= lowest_ch(ch_mask);
      else if ((state == STORE || to_fire) && state_nx == SEL)
        addr <= next_ch(addr, ch_mask);
      if (state == READ && phase == 2'd2) data_reg <= result;
      sample_valid <= (state == STORE);
      if (state == STORE) begin
        table_q[addr] <= data_reg;
        sample_ch     <= addr;
        sample_data   <= data_reg;
      end
      if (to_fire) timeout_err <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    to_fire  = 1'b0;
    case (state)
      IDLE:    if (scan_more) state_nx = SEL;
      SEL:     if (phase == 2'd1) state_nx = LATCH;
      LATCH:   if (phase == 2'd3) state_nx = CONV;
      CONV:    if (phase == 2'd3) state_nx = WAIT_LO;
      WAIT_LO: begin
        if (!eoc) state_nx = WAIT_HI;
        else if (to_last) begin
          to_fire  = 1'b1;
          state_nx = scan_more ? SEL : IDLE;
        end
      end
      WAIT_HI: begin
        if (eoc) state_nx = READ;
        else if (to_last) begin
          to_fire  = 1'b1;
          state_nx = scan_more ? SEL : IDLE;
        end
      end
      READ:    if (phase == 2'd2) state_nx = STORE;
      STORE:   state_nx = scan_more ? SEL : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered, so each one is
  // high exactly while the FSM sits in its states.
  always_comb begin
    ale_nx    = (state_nx == LATCH) || (state_nx == CONV);
    start_nx  = (state_nx == CONV);
    out_en_nx = (state_nx == READ);
    busy_nx   = (state_nx != IDLE);
  end
endmodule

// File: doc/adc_scan_ctrl.md
ADC_SCAN_CTRL -- requirements
Module: adc_scan_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 25: adc_clk half-period in clk cycles.
REQ-002 Parameter TIMEOUT, default 4096: max clk cycles allowed in WAIT_LO plus WAIT_HI.
REQ-003 clk  in  1  single system clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  scan run request.
REQ-006 ch_mask  in  8  channel enables, bit n = ADC channel n.
REQ-007 eoc  in  1  ADC end-of-conversion.
REQ-008 result  in  8  ADC data bus.
REQ-009 start / ale / out_en  out  1 each  ADC strobes.
REQ-010 adc_clk  out  1  free-running ADC clock.
REQ-011 addr  out  3  ADC mux address.
REQ-012 sample_valid  out  1  one-cycle pulse per stored sample.
REQ-013 sample_ch / sample_data  out  3 / 8  channel and value of the last sample.
REQ-014 rd_ch  in  3; rd_data  out  8  combinational read of the per-channel result table.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 timeout_err  out  1  sticky timeout flag.

Function
REQ-017 adc_clk SHALL toggle every CLK_DIV clk cycles, independent of FSM state and enable.
REQ-018 FSM states SHALL be IDLE, SEL, LATCH, CONV, WAIT_LO, WAIT_HI, READ, STORE.
REQ-019 IDLE -> SEL when enable=1 and ch_mask!=0, loading the selected channel into addr.
REQ-020 SEL SHALL hold addr stable for 2 cycles with all strobes low, then go to LATCH.
REQ-021 LATCH SHALL drive ale=1 for 4 cycles, then go to CONV.
REQ-022 CONV SHALL drive ale=1 and start=1 for 4 cycles, then go to WAIT_LO.
REQ-023 WAIT_LO SHALL wait for eoc=0, then go to WAIT_HI; WAIT_HI SHALL wait for eoc=1, then go to READ.
REQ-024 READ SHALL drive out_en=1 for 3 cycles and capture result on the 3rd cycle.
REQ-025 STORE (1 cycle) SHALL write the table entry for addr, update sample_ch/sample_data, pulse sample_valid, then select the next channel.
REQ-026 Next channel SHALL be the first set ch_mask bit above the current addr in ascending order, wrapping 7->0; the current channel is chosen if it is the only bit set.
REQ-027 After STORE: SEL if enable=1 and ch_mask!=0, else IDLE.
REQ-028 ch_mask SHALL be sampled only at channel selection; changes mid-conversion do not abort.
REQ-029 enable deasserted mid-conversion SHALL let the conversion complete and store, then return to IDLE.
REQ-030 A timeout counter SHALL clear on entry to WAIT_LO; when it reaches TIMEOUT in WAIT_LO/WAIT_HI, the FSM SHALL set timeout_err, skip READ/STORE (no sample_valid, table unchanged) and select the next channel as in REQ-027.
REQ-031 timeout_err SHALL clear only on reset.
REQ-032 Each strobe SHALL be a registered output, glitch-free, and high only in the states listed.

Reset
REQ-033 On reset: FSM=IDLE; start, ale, out_en, adc_clk, sample_valid, busy, timeout_err = 0; addr, sample_ch = 0; sample_data = 0; all 8 table entries = 0.
REQ-034 Reset asserted mid-conversion SHALL force the reset values immediately and discard the conversion in progress.

Verification
REQ-035 ch_mask=8'h01, enable=1, ADC model eoc low 10 cycles after start then result=8'hA5 -> ale 4+4 cycles, start 4 cycles, out_en 3 cycles, sample_valid with sample_ch=0/sample_data=A5, rd_ch=0 reads A5.
REQ-036 ch_mask=8'h92, channel n returns 8'h10+n -> stored order 1,4,7,1,...; rd_data for ch 1/4/7 = 11/14/17; ch 0 stays 00.
REQ-037 eoc held high forever, TIMEOUT=64 -> timeout_err=1 after 64 wait cycles, no sample_valid, FSM advances to next channel.
REQ-038 enable dropped during WAIT_HI -> conversion stores, then busy=0 and IDLE; ch_mask=0 with enable=1 -> stays IDLE.
REQ-039 reset asserted in READ -> all outputs and table return to 0 asynchronously; adc_clk restarts from 0 after release.
